// File: rtl/fetch_branch_unit_pkg.sv
// Shared constants and helpers for the fetch/branch stage and the ID decoder.
package fetch_branch_unit_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000; // sll $0,$0,0

    localparam logic [5:0] OP_J   = 6'h02;
    localparam logic [5:0] OP_BEQ = 6'h04;
    localparam logic [5:0] OP_BNE = 6'h05;

    typedef enum logic [1:0] {
        PC_SEQ,
        PC_BRANCH,
        PC_JUMP,
        PC_HOLD
    } pc_sel_t;

    function automatic logic [31:0] branch_target(input logic [31:0] pc4, input logic [31:0] imm);
        return pc4 + (imm << 2);
    endfunction

    function automatic logic [31:0] jump_target(input logic [31:0] pc4, input logic [25:0] index);
        return {pc4[31:28], index, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_branch_unit_next_pc_mux.sv
// Combinational next-PC selection: hold, sequential, branch or jump target.
module next_pc_mux
    import fetch_branch_unit_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] ifid_pc4,
    input  logic [31:0] imm_ext,
    input  logic [25:0] jump_index,
    input  pc_sel_t     sel,
    output logic [31:0] next_pc
);

    always_comb begin
        next_pc = pc + 32'd4;
        unique case (sel)
            PC_HOLD:   next_pc = pc;
            PC_JUMP:   next_pc = jump_target(ifid_pc4, jump_index);
            PC_BRANCH: next_pc = branch_target(ifid_pc4, imm_ext);
            default:   next_pc = pc + 32'd4;
        endcase
    end

endmodule

// File: rtl/fetch_branch_unit.sv
// PC register and IF/ID pipeline register with ID-stage branch/jump resolution.
module fetch_branch_unit
    import fetch_branch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_eq,
    input  logic        branch_ne,
    input  logic        jump,
    input  logic        equal,
    input  logic [31:0] imm_ext,
    input  logic [25:0] jump_index,
    input  logic [31:0] imem_data,
    output logic [31:0] pc,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc4,
    output logic        ifid_valid,
    output logic        flush,
    output logic [15:0] taken_count
);

    logic        v;
    logic        br_taken;
    logic        jmp_taken;
    logic        taken;
    logic [31:0] pc4;
    logic [31:0] next_pc;
    logic [15:0] taken_cnt;
    pc_sel_t     sel;

    assign v         = ifid_valid & ~stall;
    assign br_taken  = v & ((branch_eq & equal) | (branch_ne & ~equal));
    assign jmp_taken = v & jump;
    assign taken     = br_taken | jmp_taken;
    assign flush     = ~reset & taken;
    assign pc4       = pc + 32'd4;

    // Stall outranks any resolution because the ID operands are not yet valid.
    always_comb begin
        sel = PC_SEQ;
        if (stall)
            sel = PC_HOLD;
        else if (jmp_taken)
            sel = PC_JUMP;
        else if (br_taken)
            sel = PC_BRANCH;
    end

    next_pc_mux u_next_pc_mux (
        .pc         (pc),
        .ifid_pc4   (ifid_pc4),
        .imm_ext    (imm_ext),
        .jump_index (jump_index),
        .sel        (sel),
        .next_pc    (next_pc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            pc         <= RESET_PC;
            ifid_instr <= NOP_INSTR;
            ifid_pc4   <= '0;
            ifid_valid <= 1'b0;
        end else if (!stall) begin
            pc <= next_pc;
            if (taken) begin
                ifid_instr <= NOP_INSTR;
                ifid_valid <= 1'b0;
            end else begin
                ifid_instr <= imem_data;
                ifid_pc4   <= pc4;
                ifid_valid <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            taken_cnt <= '0;
        else if (taken && taken_cnt != '1)
            taken_cnt <= taken_cnt + 16'd1;
    end

    assign taken_count = taken_cnt;

endmodule

// File: tb/tb_fetch_branch_unit.sv
// Directed plus randomized check of fetch_branch_unit against a cycle-level reference model.
module tb_fetch_branch_unit;

    logic        clk = 1'b0;
    logic        reset, stall, branch_eq, branch_ne, jump, equal;
    logic [31:0] imm_ext, imem_data;
    logic [25:0] jump_index;
    logic [31:0] pc, ifid_instr, ifid_pc4;
    logic        ifid_valid, flush;
    logic [15:0] taken_count;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    // reference model state
    logic [31:0] m_pc = 32'h0, m_instr = 32'h0, m_pc4 = 32'h0;
    logic        m_valid = 1'b0;
    int unsigned m_cnt = 0;

    fetch_branch_unit #(.RESET_PC(32'h0000_0000), .NOP_INSTR(32'h0000_0000)) dut (
        .clk(clk), .reset(reset), .stall(stall), .branch_eq(branch_eq), .branch_ne(branch_ne),
        .jump(jump), .equal(equal), .imm_ext(imm_ext), .jump_index(jump_index),
        .imem_data(imem_data), .pc(pc), .ifid_instr(ifid_instr), .ifid_pc4(ifid_pc4),
        .ifid_valid(ifid_valid), .flush(flush), .taken_count(taken_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic model_taken_br();
        return m_valid && !stall && ((branch_eq && equal) || (branch_ne && !equal));
    endfunction

    function automatic logic model_taken_j();
        return m_valid && !stall && jump;
    endfunction

    // One clock: check flush before the edge, advance the model, check state after the edge.
    task automatic step();
        logic tb_, tj;
        logic [31:0] seq;
        #1;
        tb_ = model_taken_br();
        tj  = model_taken_j();
        chk({31'b0, flush}, {31'b0, !reset && (tb_ || tj)}, "flush");
        seq = m_pc + 32'd4;
        if (reset) begin
            m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_cnt = 0;
        end else if (!stall) begin
            if (tj)
                m_pc = {m_pc4[31:28], jump_index, 2'b00};
            else if (tb_)
                m_pc = m_pc4 + imm_ext * 32'd4;
            else
                m_pc = seq;
            if (tb_ || tj) begin
                m_instr = 32'h0; m_valid = 1'b0;
                if (m_cnt < 65535) m_cnt = m_cnt + 1;
            end else begin
                m_instr = imem_data; m_pc4 = seq; m_valid = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        chk(pc, m_pc, "pc");
        chk(ifid_instr, m_instr, "ifid_instr");
        chk(ifid_pc4, m_pc4, "ifid_pc4");
        chk({31'b0, ifid_valid}, {31'b0, m_valid}, "ifid_valid");
        chk({16'b0, taken_count}, m_cnt, "taken_count");
    endtask

    task automatic idle();
        reset = 0; stall = 0; branch_eq = 0; branch_ne = 0; jump = 0; equal = 0;
        imm_ext = 32'h0; jump_index = 26'h0;
    endtask

    // Branch from the current ID instruction to an arbitrary word-aligned target.
    task automatic branch_to(input logic [31:0] target);
        idle();
        branch_eq = 1; equal = 1;
        imm_ext = (target - m_pc4) >> 2;
        step();
        idle();
    endtask

    initial begin
        idle();
        imem_data = 32'h2008_0005;
        reset = 1;
        step(); chk(pc, 32'h0, "reset_pc_1");
        step(); chk(pc, 32'h0, "reset_pc_2");
        chk({31'b0, ifid_valid}, 32'h0, "reset_valid");
        reset = 0;
        step();
        chk(pc, 32'h4, "first_pc");
        chk(ifid_instr, 32'h2008_0005, "first_instr");
        chk(ifid_pc4, 32'h4, "first_pc4");
        step(); chk(pc, 32'h8, "second_pc");
        step(); step();

        // beq taken with ifid_pc4=0x10, imm=3
        chk(ifid_pc4, 32'h10, "beq_pc4");
        branch_eq = 1; equal = 1; imm_ext = 32'h3;
        #1; chk({31'b0, flush}, 32'h1, "beq_flush");
        step(); idle();
        chk(pc, 32'h1C, "beq_target");
        chk({31'b0, ifid_valid}, 32'h0, "beq_bubble");
        chk({16'b0, taken_count}, 32'h1, "beq_count");
        step();

        // bne not taken
        chk(ifid_pc4, 32'h20, "bne_pc4");
        branch_ne = 1; equal = 1;
        step(); idle();
        chk(pc, 32'h24, "bne_seq");
        chk({31'b0, ifid_valid}, 32'h1, "bne_nobubble");

        // backward beq with imm=-2 from ifid_pc4=0x40
        for (int i = 0; i < 16 && m_pc4 != 32'h40; i++) step();
        chk(ifid_pc4, 32'h40, "back_pc4");
        branch_eq = 1; equal = 1; imm_ext = 32'hFFFF_FFFE;
        step(); idle();
        chk(pc, 32'h38, "back_target");
        step();

        // jump held by a 2-cycle stall, resolved once stall drops
        branch_to(32'hA000_0000);
        step();
        chk(ifid_pc4, 32'hA000_0004, "jmp_pc4");
        jump = 1; jump_index = 26'h000_0100; stall = 1;
        step(); step();
        chk(pc, 32'hA000_0004, "stall_pc_frozen");
        stall = 0;
        step(); idle();
        chk(pc, 32'hA000_0400, "jmp_target");
        chk({31'b0, ifid_valid}, 32'h0, "jmp_bubble");
        step();

        // sequential wrap at the top of the address space
        branch_to(32'hFFFF_FFFC);
        step();
        chk(pc, 32'h0, "pc_wrap");
        chk(ifid_pc4, 32'h0, "pc4_wrap");

        // counter saturation
        force dut.taken_cnt = 16'hFFFE;
        #1;
        release dut.taken_cnt;
        m_cnt = 16'hFFFE;
        jump = 1; jump_index = 26'h0000040;
        step(); idle();
        chk({16'b0, taken_count}, 32'hFFFF, "sat_reach");
        step();
        jump = 1; jump_index = 26'h0000080;
        step(); idle();
        chk({16'b0, taken_count}, 32'hFFFF, "sat_hold");
        step();

        // reset on the same edge as a taken beq
        branch_eq = 1; equal = 1; imm_ext = 32'h10; reset = 1;
        step(); idle();
        chk(pc, 32'h0, "rst_flush_pc");
        chk({31'b0, ifid_valid}, 32'h0, "rst_flush_valid");
        chk({16'b0, taken_count}, 32'h0, "rst_flush_cnt");

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            reset      = ($urandom_range(0, 49) == 0);
            stall      = ($urandom_range(0, 3) == 0);
            branch_eq  = ($urandom_range(0, 3) == 0);
            branch_ne  = ($urandom_range(0, 3) == 0);
            jump       = ($urandom_range(0, 7) == 0);
            equal      = $urandom_range(0, 1) == 1;
            imm_ext    = {{16{1'($urandom_range(0, 1))}}, 16'($urandom())};
            jump_index = 26'($urandom());
            imem_data  = $urandom();
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
